// File: rtl/prbs31_checker.sv
// Self-synchronising serial PRBS31 (x^31 + x^28 + 1) checker with HUNT/LOCKED lock FSM.
// Define PRBS31_CHECKER_BITCNT_EN to build the 32-bit checked-bit counter (bit_count).
module prbs31_checker #(
  parameter int LOCK_CNT   = 64,
  parameter int WINDOW     = 64,
  parameter int ERR_THRESH = 8,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [31:0]      bit_count
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam logic [4:0]    FILL_LAST  = 5'd31;
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] WIN_LAST   = BW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_THRESH - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state, state_n;
  logic [30:0]     sr, sr_n;
  logic [4:0]      fill_cnt, fill_n;
  logic [MW-1:0]   match_cnt, match_n;
  logic [BW-1:0]   win_bits, win_bits_n;
  logic [EW-1:0]   win_errs, win_errs_n;
  logic            predicted, mismatch, pulse_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      fill_cnt  <= fill_n;
      match_cnt <= match_n;
      win_bits  <= win_bits_n;
      win_errs  <= win_errs_n;
      locked    <= (state_n == LOCKED);
      err_pulse <= pulse_n;
      if (clr_err) begin
        err_count <= '0;
      end else if (pulse_n && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

  // The all-zero register is a degenerate LFSR state, so it always counts as a mismatch.
  always_comb begin
    predicted  = sr[30] ^ sr[27];
    mismatch   = (din != predicted) || (sr == '0);
    state_n    = state;
    sr_n       = sr;
    fill_n     = fill_cnt;
    match_n    = match_cnt;
    win_bits_n = win_bits;
    win_errs_n = win_errs;
    pulse_n    = 1'b0;
    if (en) begin
      sr_n = {sr[29:0], din};
      case (state)
        HUNT: begin
          if (fill_cnt != FILL_LAST) begin
            fill_n = fill_cnt + 1'b1;
          end else if (mismatch) begin
            match_n = '0;
          end else if (match_cnt == MATCH_LAST) begin
            state_n = LOCKED;
            match_n = '0;
          end else begin
            match_n = match_cnt + 1'b1;
          end
        end
        LOCKED: begin
          pulse_n = mismatch;
          if (mismatch && (win_errs == ERR_LAST)) begin
            state_n    = HUNT;
            fill_n     = '0;
            match_n    = '0;
            win_bits_n = '0;
            win_errs_n = '0;
          end else if (win_bits == WIN_LAST) begin
            win_bits_n = '0;
            win_errs_n = '0;
          end else begin
            win_bits_n = win_bits + 1'b1;
            win_errs_n = win_errs + {{(EW-1){1'b0}}, mismatch};
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

`ifdef PRBS31_CHECKER_BITCNT_EN
  logic [31:0] bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (clr_err) begin
      bit_cnt <= '0;
    end else if (en && (state == LOCKED)) begin
      bit_cnt <= bit_cnt + 32'd1;
    end
  end

  assign bit_count = bit_cnt;
`else
  assign bit_count = 32'd0;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: directed PRBS31 streams, expected outputs queued per driven bit
// and compared by an independent monitor one edge later.
module tb_prbs31_checker;
  localparam int ERR_W = 4;
  localparam int QW    = 2 + ERR_W + 32;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             din;
  logic             clr_err;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;
  logic [31:0]      bit_count;

  logic [QW-1:0]    exp_q[$];
  int               n_checks;
  int               n_errors;
  logic [30:0]      g;
  logic             prev_locked;
  logic [31:0]      exp_bc;

  prbs31_checker #(
    .LOCK_CNT  (64),
    .WINDOW    (64),
    .ERR_THRESH(8),
    .ERR_W     (ERR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .din      (din),
    .clr_err  (clr_err),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference generator: seed all-ones, output bit fed back into the register.
  function automatic logic prbs_next();
    logic b;
    b = g[30] ^ g[27];
    g = {g[29:0], b};
    return b;
  endfunction

  task automatic drive(input logic e, input logic d, input logic c,
                       input logic xl, input logic xp, input logic [ERR_W-1:0] xc);
    @(negedge clk);
    en      = e;
    din     = d;
    clr_err = c;
`ifdef PRBS31_CHECKER_BITCNT_EN
    if (c) exp_bc = 32'd0;
    else if (e && prev_locked) exp_bc = exp_bc + 32'd1;
`endif
    exp_q.push_back({xl, xp, xc, exp_bc});
    prev_locked = xl;
  endtask

  task automatic idle();
    @(negedge clk);
    en      = 1'b0;
    din     = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_locked"},    32'(locked),    32'd0);
    check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_bit_count"}, bit_count,      32'd0);
    prev_locked = 1'b0;
    exp_bc      = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per driven bit, just after the capturing edge.
  initial begin
    logic [QW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("locked",    32'(locked),    32'(e[QW-1]));
        check("err_pulse", 32'(err_pulse), 32'(e[QW-2]));
        check("err_count", 32'(err_count), 32'(e[32+ERR_W-1:32]));
        check("bit_count", bit_count,      e[31:0]);
      end
    end
  end

  function automatic logic sat_flip(input int k);
    return (k >= 180) && (k <= 372) && (((k - 180) % 64) == 0);
  endfunction

  function automatic logic sat_err(input int k);
    int r;
    if (k < 180 || k > 403) return 1'b0;
    r = (k - 180) % 64;
    return (r == 0) || (r == 28) || (r == 31);
  endfunction

  initial begin
    logic             b, f, p, l, c;
    logic [ERR_W-1:0] cnt;
    int               v;
    n_checks    = 0;
    n_errors    = 0;
    g           = '1;
    prev_locked = 1'b0;
    exp_bc      = 32'd0;
    rst_n       = 1'b1;
    en          = 1'b0;
    din         = 1'b0;
    clr_err     = 1'b0;

    // Power-on reset
    async_reset_check("por");

    // Clean lock at bit 95, 10k clean bits, then a single flip at bit 10050
    cnt = '0;
    for (int n = 1; n <= 10100; n++) begin
      b = prbs_next();
      f = (n == 10050);
      p = (n == 10050) || (n == 10078) || (n == 10081);
      if (p) cnt = cnt + 1'b1;
      l = (n >= 95);
      drive(1'b1, b ^ f, 1'b0, l, p, cnt);
    end
    idle();

    // Mid-stream asynchronous reset while locked with err_count = 3
    async_reset_check("mid");

    // Lock with random enable gaps: 95 valid bits regardless of gaps
    v = 0;
    while (v < 95) begin
      if ($urandom_range(0, 1) == 1) begin
        v++;
        drive(1'b1, prbs_next(), 1'b0, (v >= 95), 1'b0, '0);
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
      end
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, '0);
    end

    // Burst of 20 flips at window start, relock, then saturation and clear
    cnt = '0;
    for (int k = 1; k <= 420; k++) begin
      b = prbs_next();
      f = ((k >= 65) && (k <= 84)) || sat_flip(k);
      p = ((k >= 65) && (k <= 72)) || sat_err(k);
      l = !((k >= 72) && (k < 179));
      c = (k == 372);
      if (c) cnt = '0;
      else if (p && (cnt != '1)) cnt = cnt + 1'b1;
      drive(1'b1, b ^ f, c, l, p, cnt);
    end
    idle();

    // All-zero input never locks
    async_reset_check("zero");
    for (int n = 1; n <= 500; n++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    end
    idle();

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
